// File: rtl/fft32_frame_ctrl.sv
// Frame sequencer for the iterative 32-point radix-2 FFT.
// Arbitrates the shared register bank between serial load, five butterfly
// passes and serial unload. Optional macro FFT_INVERSE_EN adds the inverse
// input and the conj_tw output, which selects conjugated twiddles for a frame.
module fft32_frame_ctrl #(
  parameter int unsigned BFLY_LAT = 2,
  parameter int unsigned N_PTS    = 32
) (
  input  logic       clk_10,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
`ifdef FFT_INVERSE_EN
  input  logic       inverse,
  output logic       conj_tw,
`endif
  input  logic       in_valid,
  output logic       in_ready,
  output logic       wr_en,
  output logic [4:0] wr_addr,
  output logic       sel_load,
  output logic [2:0] stage,
  output logic       cap_en,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] rd_addr,
  output logic       out_last,
  output logic       busy,
  output logic       done
);

  localparam logic [4:0] LastIdx   = 5'(N_PTS - 1);
  localparam logic [3:0] LastLat   = 4'(BFLY_LAT - 1);
  localparam logic [2:0] LastStage = 3'd4;

  typedef enum logic [1:0] {StIdle, StLoad, StCompute, StUnload} state_e;

  state_e     state_q, state_d;
  logic [4:0] load_cnt_q, load_cnt_d;
  logic [3:0] lat_cnt_q, lat_cnt_d;
  logic [2:0] stage_q, stage_d;
  logic [4:0] unload_cnt_q, unload_cnt_d;
  logic       done_q, done_d;

  // Handshake and bank-control outputs decoded from the current state.
  // abort suppresses any write or capture in the cycle it is seen.
  assign in_ready  = (state_q == StLoad);
  assign wr_en     = in_valid & in_ready & ~abort;
  assign wr_addr   = {load_cnt_q[0], load_cnt_q[1], load_cnt_q[2], load_cnt_q[3], load_cnt_q[4]};
  assign sel_load  = (state_q != StCompute);
  assign stage     = stage_q;
  assign cap_en    = (state_q == StCompute) & (lat_cnt_q == LastLat) & ~abort;
  assign out_valid = (state_q == StUnload);
  assign rd_addr   = unload_cnt_q;
  assign out_last  = out_valid & (unload_cnt_q == LastIdx);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

  // Next-state logic: abort dominates everything, then the per-phase counters.
  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    stage_d      = stage_q;
    unload_cnt_d = unload_cnt_q;
    done_d       = 1'b0;
    if (abort) begin
      state_d      = StIdle;
      load_cnt_d   = '0;
      lat_cnt_d    = '0;
      stage_d      = '0;
      unload_cnt_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_d    = StLoad;
            load_cnt_d = '0;
          end
        end
        StLoad: begin
          if (wr_en) begin
            load_cnt_d = load_cnt_q + 5'd1;
            if (load_cnt_q == LastIdx) begin
              state_d   = StCompute;
              lat_cnt_d = '0;
              stage_d   = '0;
            end
          end
        end
        StCompute: begin
          if (cap_en) begin
            lat_cnt_d = '0;
            // Stage stays at 4 through unload; it clears at frame end.
            if (stage_q == LastStage) state_d = StUnload;
            else                      stage_d = stage_q + 3'd1;
          end else begin
            lat_cnt_d = lat_cnt_q + 4'd1;
          end
        end
        StUnload: begin
          if (out_ready) begin
            if (unload_cnt_q == LastIdx) begin
              state_d      = StIdle;
              unload_cnt_d = '0;
              stage_d      = '0;
              done_d       = 1'b1;
            end else begin
              unload_cnt_d = unload_cnt_q + 5'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk_10 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      load_cnt_q   <= '0;
      lat_cnt_q    <= '0;
      stage_q      <= '0;
      unload_cnt_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      stage_q      <= stage_d;
      unload_cnt_q <= unload_cnt_d;
      done_q       <= done_d;
    end
  end

`ifdef FFT_INVERSE_EN
  logic conj_tw_q;

  assign conj_tw = conj_tw_q;

  // Twiddle direction latched on the start handshake and held for the frame.
  always_ff @(posedge clk_10 or negedge rst_n) begin
    if (!rst_n) begin
      conj_tw_q <= 1'b0;
    end else if (abort) begin
      conj_tw_q <= 1'b0;
    end else if ((state_q == StIdle) && start) begin
      conj_tw_q <= inverse;
    end
  end
`endif

endmodule

// File: tb/tb_fft32_frame_ctrl.sv
// Self-checking bench for fft32_frame_ctrl (BFLY_LAT = 3).
// Table-driven control vectors plus scoreboarded load/unload frames.
module tb_fft32_frame_ctrl;

  logic       clk_10 = 1'b0;
  logic       rst_n;
  logic       start, abort, in_valid, out_ready;
  logic       in_ready, wr_en, sel_load, cap_en, out_valid, out_last, busy, done;
  logic [4:0] wr_addr, rd_addr;
  logic [2:0] stage;
`ifdef FFT_INVERSE_EN
  logic       inverse, conj_tw;
`endif

  fft32_frame_ctrl #(.BFLY_LAT(3), .N_PTS(32)) dut (
    .clk_10    (clk_10),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
`ifdef FFT_INVERSE_EN
    .inverse   (inverse),
    .conj_tw   (conj_tw),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .sel_load  (sel_load),
    .stage     (stage),
    .cap_en    (cap_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd_addr   (rd_addr),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk_10 = ~clk_10;

  typedef struct packed {
    logic       start, abort, in_valid;
    logic       busy, in_ready, wr_en, sel_load;
    logic [4:0] wr_addr;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_wr, n_cap, n_done;
  bit   mon_en   = 0;
  int   wr_q[$];
  int   rd_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] bitrev(input int k);
    logic [4:0] a, r;
    a = 5'(k);
    for (int i = 0; i < 5; i++) r[i] = a[4-i];
    return r;
  endfunction

  function automatic vec_t mk(input logic s, ab, iv, b, ir, we, sl, input logic [4:0] wa);
    vec_t v;
    v.start = s; v.abort = ab; v.in_valid = iv;
    v.busy = b; v.in_ready = ir; v.wr_en = we; v.sel_load = sl; v.wr_addr = wa;
    return v;
  endfunction

  // Sample at the falling edge; scoreboard pops happen here.
  task automatic sample();
    @(negedge clk_10);
    if (mon_en) begin
      if (wr_en) begin
        n_wr++;
        if (wr_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL wr_unexpected: got wr_en=1 at wr_addr %0d, expected no write", wr_addr);
        end else check("wr_addr_sb", 32'(wr_addr), 32'(wr_q.pop_front()));
      end
      if (out_valid && out_ready) begin
        if (rd_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rd_unexpected: got accept at rd_addr %0d, expected none", rd_addr);
        end else check("rd_addr_sb", 32'(rd_addr), 32'(rd_q.pop_front()));
      end
      check("wr_cap_excl", 32'(wr_en & cap_en), 32'd0);
      if (cap_en) n_cap++;
      if (done)   n_done++;
    end
  endtask

  task automatic advance();
    @(posedge clk_10);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd0);
    check({tag, "_wr_en"},     32'(wr_en),     32'd0);
    check({tag, "_cap_en"},    32'(cap_en),    32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_last"},  32'(out_last),  32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
    check({tag, "_rd_addr"},   32'(rd_addr),   32'd0);
    check({tag, "_stage"},     32'(stage),     32'd0);
    check({tag, "_sel_load"},  32'(sel_load),  32'd1);
  endtask

  vec_t       vt[13];
  logic [3:0] rdy_pat = 4'b1001;

  initial begin
    int k, exp_rd, cap_before, done_before;
    rst_n = 1'b0; start = 0; abort = 0; in_valid = 0; out_ready = 0;
`ifdef FFT_INVERSE_EN
    inverse = 0;
`endif
    #2;
    check_reset_outputs("reset");
    advance(); advance();
    rst_n = 1'b1;

    // Control vectors: start/abort interplay and early load addressing.
    vt[0]  = mk(0, 0, 0, 0, 0, 0, 1, 5'd0);
    vt[1]  = mk(1, 1, 0, 0, 0, 0, 1, 5'd0);
    vt[2]  = mk(0, 0, 0, 0, 0, 0, 1, 5'd0);
    vt[3]  = mk(1, 0, 0, 0, 0, 0, 1, 5'd0);
    vt[4]  = mk(0, 0, 1, 1, 1, 1, 1, 5'd0);
    vt[5]  = mk(0, 0, 0, 1, 1, 0, 1, 5'd16);
    vt[6]  = mk(0, 0, 1, 1, 1, 1, 1, 5'd16);
    vt[7]  = mk(0, 1, 1, 1, 1, 0, 1, 5'd8);
    vt[8]  = mk(0, 0, 1, 0, 0, 0, 1, 5'd0);
    vt[9]  = mk(1, 0, 1, 0, 0, 0, 1, 5'd0);
    vt[10] = mk(0, 0, 1, 1, 1, 1, 1, 5'd0);
    vt[11] = mk(0, 1, 0, 1, 1, 0, 1, 5'd16);
    vt[12] = mk(0, 0, 0, 0, 0, 0, 1, 5'd0);
    for (int i = 0; i < 13; i++) begin
      start = vt[i].start; abort = vt[i].abort; in_valid = vt[i].in_valid;
      sample();
      check($sformatf("vec%0d_busy", i),     32'(busy),     32'(vt[i].busy));
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vt[i].in_ready));
      check($sformatf("vec%0d_wr_en", i),    32'(wr_en),    32'(vt[i].wr_en));
      check($sformatf("vec%0d_sel_load", i), 32'(sel_load), 32'(vt[i].sel_load));
      check($sformatf("vec%0d_wr_addr", i),  32'(wr_addr),  32'(vt[i].wr_addr));
      advance();
    end
    start = 0; abort = 0; in_valid = 0;

    // Full frame: gapped load, compute timing, throttled unload.
    mon_en = 1; n_wr = 0; n_cap = 0; n_done = 0;
    start = 1; sample(); advance(); start = 0;
    k = 0;
    for (int c = 0; c < 200 && k < 32; c++) begin
      in_valid = (c % 2 == 0);
      if (in_valid) begin wr_q.push_back(int'(bitrev(k))); k++; end
      sample();
      check("load_in_ready", 32'(in_ready), 32'd1);
      advance();
    end
    in_valid = 0;
    check("load_count", 32'(k), 32'd32);
    for (int c = 1; c <= 15; c++) begin
      start = (c == 5);
      sample();
      check("cmp_sel_load", 32'(sel_load), 32'd0);
      check("cmp_in_ready", 32'(in_ready), 32'd0);
      check($sformatf("cmp_cap_c%0d", c), 32'(cap_en), 32'(c % 3 == 0));
      if (c % 3 == 0) check($sformatf("cmp_stage_c%0d", c), 32'(stage), 32'(c / 3 - 1));
      advance();
    end
    start = 0;
    check("cap_pulses", 32'(n_cap), 32'd5);
    exp_rd = 0;
    for (int c = 0; c < 200 && exp_rd < 32; c++) begin
      out_ready = rdy_pat[c % 4];
      if (out_ready) rd_q.push_back(exp_rd);
      sample();
      if (c == 0) check("unl_stage", 32'(stage), 32'd4);
      check("unl_valid", 32'(out_valid), 32'd1);
      check("unl_rd_addr", 32'(rd_addr), 32'(exp_rd));
      check("unl_last", 32'(out_last), 32'(exp_rd == 31));
      advance();
      if (out_ready) exp_rd++;
    end
    out_ready = 0;
    check("unload_count", 32'(exp_rd), 32'd32);
    sample();
    check("done_pulse", 32'(done), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_stage", 32'(stage), 32'd0);
    check("end_out_valid", 32'(out_valid), 32'd0);
    advance(); sample();
    check("done_drop", 32'(done), 32'd0);
    advance();
    check("wr_pulses", 32'(n_wr), 32'd32);
    check("done_count", 32'(n_done), 32'd1);
    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);

    // Abort in stage 2; a start during compute must be ignored.
    start = 1; sample(); advance(); start = 0;
    for (int i = 0; i < 32; i++) begin
      in_valid = 1; wr_q.push_back(int'(bitrev(i)));
      sample(); advance();
    end
    in_valid = 0;
    for (int c = 1; c <= 7; c++) begin
      start = (c == 2);
      abort = (c == 7);
      sample();
      check("ab_busy", 32'(busy), 32'd1);
      if (c == 7) check("ab_stage2", 32'(stage), 32'd2);
      advance();
    end
    start = 0; abort = 0;
    cap_before = n_cap; done_before = n_done;
    sample();
    check("ab_idle_busy", 32'(busy), 32'd0);
    check("ab_sel_load", 32'(sel_load), 32'd1);
    check("ab_stage0", 32'(stage), 32'd0);
    check("ab_out_valid", 32'(out_valid), 32'd0);
    advance();
    for (int c = 0; c < 20; c++) begin sample(); advance(); end
    check("ab_no_cap", 32'(n_cap), 32'(cap_before));
    check("ab_no_done", 32'(n_done), 32'(done_before));

    // Reset mid-load after 10 samples, then reload from address 0.
    start = 1; sample(); advance(); start = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; wr_q.push_back(int'(bitrev(i)));
      sample(); advance();
    end
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midrst");
    sample(); advance();
    rst_n = 1'b1; in_valid = 0;
    start = 1; sample(); advance(); start = 0;
    in_valid = 1; wr_q.push_back(0);
    sample();
    check("reload_wr_en", 32'(wr_en), 32'd1);
    check("reload_wr_addr", 32'(wr_addr), 32'd0);
    advance();
    in_valid = 0; abort = 1; sample(); advance(); abort = 0;

`ifdef FFT_INVERSE_EN
    // Inverse flag captured at start, held across the frame, cleared by abort.
    inverse = 1; start = 1; sample(); advance(); start = 0;
    inverse = 0;
    for (int c = 0; c < 4; c++) begin
      sample(); check("conj_hold", 32'(conj_tw), 32'd1); advance();
      inverse = ~inverse;
    end
    abort = 1; sample(); advance(); abort = 0;
    sample(); check("conj_abort", 32'(conj_tw), 32'd0); advance();
`endif

    check("final_q_empty", 32'(wr_q.size() + rd_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
